pipe_hazard_unit: RTL and testbench

//  Parametrised data-hazard unit for the FE/ID/EX/MEM/WB pipeline. Generalises the fixed
//  EX/MEM destination-register compare to DEPTH tracked stages past ID, of any data/register width.

---
 rtl/pipe_hazard_unit.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - data-hazard unit: forwarding, load-use stall, flush bubbles, stall counter
//
// Purpose: tracks DEPTH in-flight instructions past ID (entry 0 = EX, youngest)
//   and, for the two ID source registers, either forwards the youngest
//   in-flight result or stalls FE/ID when that result is a load not yet ready.
// Ports:
//   CLOCK_50      clock, rising edge
//   reset_n       asynchronous active-low reset
//   id_valid      ID holds a real instruction
//   id_src1/2     source registers, id_src1_used/id_src2_used mark real reads
//   id_dst        destination register, id_wr_en marks a real write
//   id_is_load    ID instruction is a memory load
//   flush         kill the ID instruction (taken branch in EX)
//   stage_result  per-entry results, entry k at [k*DATA_W +: DATA_W]
//   stall         hold FE/ID this cycle (combinational)
//   fwd1_en/data  forwarded src1 operand
//   fwd2_en/data  forwarded src2 operand
//   stall_count   saturating count of stall cycles
module pipe_hazard_unit #(
  parameter int DATA_W     = 16,
  parameter int RADDR_W    = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int ZERO_REG   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  input  logic                      id_valid,
  input  logic [RADDR_W-1:0]        id_src1,
  input  logic                      id_src1_used,
  input  logic [RADDR_W-1:0]        id_src2,
  input  logic                      id_src2_used,
  input  logic [RADDR_W-1:0]        id_dst,
  input  logic                      id_wr_en,
  input  logic                      id_is_load,
  input  logic                      flush,
  input  logic [DEPTH*DATA_W-1:0]   stage_result,
  output logic                      stall,
  output logic                      fwd1_en,
  output logic [DATA_W-1:0]         fwd1_data,
  output logic                      fwd2_en,
  output logic [DATA_W-1:0]         fwd2_data,
  output logic [CNT_W-1:0]          stall_count
);

  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:0]   r_wr_en;
  logic [DEPTH-1:0]   r_is_load;
  logic [RADDR_W-1:0] r_dst [DEPTH];
  logic [CNT_W-1:0]   r_stall_count;

  logic [RADDR_W-1:0] w_src [2];
  logic [1:0]         w_used;
  logic [1:0]         w_hit;
  logic [1:0]         w_hazard;
  logic [DATA_W-1:0]  w_data [2];
  logic [1:0]         w_fwd_en;
  logic               w_stall;
  logic               w_accept;

  assign w_src[0]  = id_src1;
  assign w_src[1]  = id_src2;
  assign w_used[0] = id_src1_used;
  assign w_used[1] = id_src2_used;

  // The scan runs oldest to youngest so the youngest matching entry is the
  // last to assign, i.e. it wins over older writers of the same register.
  always_comb begin
    w_hit    = '0;
    w_hazard = '0;
    for (int s = 0; s < 2; s++) begin
      w_data[s] = '0;
      if (w_used[s] && (ZERO_REG == 0 || w_src[s] != '0)) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (r_valid[k] && r_wr_en[k] && r_dst[k] == w_src[s]) begin
            w_hit[s]    = 1'b1;
            w_hazard[s] = r_is_load[k] && (k < LOAD_STAGE);
            w_data[s]   = stage_result[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign w_fwd_en = w_hit & ~w_hazard;
  // flush dominates a hazard: the killed instruction must not hold the front end.
  assign w_stall  = id_valid && !flush && (|w_hazard);
  assign w_accept = id_valid && !w_stall && !flush;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_valid       <= '0;
      r_wr_en       <= '0;
      r_is_load     <= '0;
      r_stall_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_dst[k] <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k]   <= r_valid[k-1];
        r_wr_en[k]   <= r_wr_en[k-1];
        r_is_load[k] <= r_is_load[k-1];
        r_dst[k]     <= r_dst[k-1];
      end
      // A stalled or flushed ID enters EX as a bubble (valid=0).
      r_valid[0]   <= w_accept;
      r_wr_en[0]   <= id_wr_en;
      r_is_load[0] <= id_is_load;
      r_dst[0]     <= id_dst;
      if (w_stall && r_stall_count != '1) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign stall       = w_stall;
  assign fwd1_en     = w_fwd_en[0];
  assign fwd2_en     = w_fwd_en[1];
  assign fwd1_data   = w_fwd_en[0] ? w_data[0] : '0;
  assign fwd2_data   = w_fwd_en[1] ? w_data[1] : '0;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - self-checking bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        id_valid, id_src1_used, id_src2_used, id_wr_en, id_is_load, flush;
  logic [2:0]  id_src1, id_src2, id_dst;
  logic [15:0] sr [3];
  logic [47:0] stage_result;

  logic        a_stall, a_f1en, a_f2en, b_stall, b_f1en, b_f2en;
  logic [15:0] a_f1d, a_f2d, b_f1d, b_f2d, a_cnt;
  logic [3:0]  b_cnt;

  assign stage_result = {sr[2], sr[1], sr[0]};

  always #5 CLOCK_50 = ~CLOCK_50;

  pipe_hazard_unit dut_a (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used), .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .stage_result(stage_result), .stall(a_stall), .fwd1_en(a_f1en), .fwd1_data(a_f1d),
    .fwd2_en(a_f2en), .fwd2_data(a_f2d), .stall_count(a_cnt)
  );

  pipe_hazard_unit #(.ZERO_REG(1), .CNT_W(4)) dut_b (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used), .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .stage_result(stage_result), .stall(b_stall), .fwd1_en(b_f1en), .fwd1_data(b_f1d),
    .fwd2_en(b_f2en), .fwd2_data(b_f2d), .stall_count(b_cnt)
  );

  // Reference model: per unit, the last three issued slots (age 0 = most recent).
  typedef struct packed {
    logic       v;
    logic [2:0] d;
    logic       w;
    logic       l;
  } slot_t;

  slot_t       hist [2][3];
  int          mcnt [2];
  int          cmax [2];
  int          zreg [2];
  logic        e_stall [2];
  logic        e_en [2][2];
  logic [15:0] e_dat [2][2];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      mcnt[u] = 0;
      for (int a = 0; a < 3; a++) hist[u][a] = '0;
    end
  endtask

  // A source takes its value from the most recent in-flight writer; a load
  // younger than one stage past EX has no data yet, which forces a stall.
  task automatic model_eval();
    for (int u = 0; u < 2; u++) begin
      logic haz;
      haz = 1'b0;
      for (int s = 0; s < 2; s++) begin
        logic [2:0] src;
        logic       used, found;
        src   = (s == 0) ? id_src1 : id_src2;
        used  = (s == 0) ? id_src1_used : id_src2_used;
        found = 1'b0;
        e_en[u][s]  = 1'b0;
        e_dat[u][s] = 16'h0;
        if (used && !(zreg[u] == 1 && src == 3'd0)) begin
          for (int a = 0; a < 3; a++) begin
            if (!found && hist[u][a].v && hist[u][a].w && hist[u][a].d == src) begin
              found = 1'b1;
              if (hist[u][a].l && a < 1) haz = 1'b1;
              else begin
                e_en[u][s]  = 1'b1;
                e_dat[u][s] = sr[a];
              end
            end
          end
        end
      end
      e_stall[u] = id_valid && !flush && haz;
    end
  endtask

  task automatic model_clock();
    for (int u = 0; u < 2; u++) begin
      if (e_stall[u] && mcnt[u] < cmax[u]) mcnt[u]++;
      hist[u][2] = hist[u][1];
      hist[u][1] = hist[u][0];
      if (id_valid && !flush && !e_stall[u]) hist[u][0] = {1'b1, id_dst, id_wr_en, id_is_load};
      else hist[u][0] = '0;
    end
  endtask

  task automatic compare_all();
    model_eval();
    chk("a_stall", a_stall, e_stall[0]);
    chk("a_fwd1_en", a_f1en, e_en[0][0]);
    chk("a_fwd1_data", a_f1d, e_dat[0][0]);
    chk("a_fwd2_en", a_f2en, e_en[0][1]);
    chk("a_fwd2_data", a_f2d, e_dat[0][1]);
    chk("a_count", a_cnt, mcnt[0]);
    chk("b_stall", b_stall, e_stall[1]);
    chk("b_fwd1_en", b_f1en, e_en[1][0]);
    chk("b_fwd1_data", b_f1d, e_dat[1][0]);
    chk("b_fwd2_en", b_f2en, e_en[1][1]);
    chk("b_fwd2_data", b_f2d, e_dat[1][1]);
    chk("b_count", b_cnt, mcnt[1]);
  endtask

  task automatic step();
    compare_all();
    @(posedge CLOCK_50);
    model_clock();
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                       input logic u2, input logic [2:0] d, input logic w, input logic l, input logic fl);
    id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
    id_dst = d; id_wr_en = w; id_is_load = l; flush = fl;
    #1;
  endtask

  task automatic reset_check(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, "_stall"}, a_stall, 1'b0);
    chk({tag, "_f1en"}, a_f1en, 1'b0);
    chk({tag, "_f2en"}, a_f2en, 1'b0);
    chk({tag, "_f1d"}, a_f1d, 16'h0);
    chk({tag, "_cnt"}, a_cnt, 16'h0);
    chk({tag, "_b_cnt"}, b_cnt, 4'h0);
    model_clear();
    @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int saved;
    logic hold;
    cmax[0] = 65535; cmax[1] = 15;
    zreg[0] = 0;     zreg[1] = 1;
    model_clear();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) sr[i] = 16'h0;
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset_check("rst0");

    // ALU chain: r1 produced in EX is forwarded to the next instruction.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0); step();
    sr[0] = 16'h0005;
    drive(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    chk("alu_fwd1_en", a_f1en, 1'b1);
    chk("alu_fwd1_data", a_f1d, 16'h0005);
    chk("alu_stall", a_stall, 1'b0);
    step();

    // Load-use: one stall cycle, then the load value arrives from MEM.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0); step();
    drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", a_stall, 1'b1);
    step();
    sr[1] = 16'hBEEF;
    drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("lu_count", a_cnt, 16'd1);
    chk("lu_fwd1_data", a_f1d, 16'hBEEF);
    chk("lu_fwd2_data", a_f2d, 16'hBEEF);
    chk("lu_stall_clear", a_stall, 1'b0);
    step();

    // Youngest writer of r5 wins over the older one in WB.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0); step();
    sr[0] = 16'h0001; sr[2] = 16'h0002;
    drive(1'b1, 3'd5, 1'b1, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("young_fwd1_data", a_f1d, 16'h0001);
    step();

    // Flush beats a load-use hazard.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0); step();
    saved = mcnt[0];
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1);
    chk("flush_stall", a_stall, 1'b0);
    step();
    drive(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    chk("flush_count", a_cnt, saved);
    chk("flush_bubble_no_fwd", a_f1en, 1'b0);
    step();

    // Saturation of the 4-bit counter over 20 load-use stalls.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0); step();
      drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0); step();
      step();
    end
    chk("sat_b_count", b_cnt, 4'hF);

    // r0 in flight: hard-wired zero unit never forwards it.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    chk("zero_b_fwd1_en", b_f1en, 1'b0);
    chk("zero_a_fwd1_en", a_f1en, 1'b1);
    step();

    // Random traffic; a stalled instruction is re-presented unchanged.
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) sr[k] = 16'($urandom);
      if (!hold) begin
        drive($urandom_range(0, 99) < 85, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
              3'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
              $urandom_range(0, 9) == 0);
      end else begin
        flush = $urandom_range(0, 9) == 0;
        #1;
      end
      if (i == 200) begin
        reset_check("rst_mid");
        hold = 1'b0;
      end else begin
        step();
        hold = e_stall[0] || e_stall[1];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
